// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_LINES  = 16;
    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_LINE_WIDTH = DEF_LINE_BYTES * 8;

    typedef logic [DEF_DATA_WIDTH-1:0] instruction_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } icache_state_t;

    function automatic int off_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_lines, input int line_bytes);
        return addr_width - $clog2(num_lines) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-port and backing-memory signals of the instruction cache.
interface icache_if #(
    parameter int ADDR_WIDTH = icache_pkg::DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = icache_pkg::DEF_LINE_WIDTH
);

    logic                     req_valid_i;
    logic [ADDR_WIDTH-1:0]    req_pc_i;
    logic                     req_ready_o;
    logic                     instr_valid_o;
    icache_pkg::instruction_t instr_o;
    logic                     flush_i;
    logic                     mem_req_valid_o;
    logic [ADDR_WIDTH-1:0]    mem_req_addr_o;
    logic                     mem_resp_valid_i;
    logic [LINE_WIDTH-1:0]    mem_resp_data_i;

    modport slave (
        input  req_valid_i, req_pc_i, flush_i, mem_resp_valid_i, mem_resp_data_i,
        output req_ready_o, instr_valid_o, instr_o, mem_req_valid_o, mem_req_addr_o
    );

    modport master (
        output req_valid_i, req_pc_i, flush_i, mem_resp_valid_i, mem_resp_data_i,
        input  req_ready_o, instr_valid_o, instr_o, mem_req_valid_o, mem_req_addr_o
    );

endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read, single write port, flush-all.
module icache_array #(
    parameter int NUM_LINES  = 16,
    parameter int IDX_BITS   = 4,
    parameter int TAG_BITS   = 24,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_BITS-1:0]   rd_idx_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  rd_hit_o,
    output logic [LINE_WIDTH-1:0] rd_line_o,
    input  logic                  wr_en_i,
    input  logic [IDX_BITS-1:0]   wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [LINE_WIDTH-1:0] wr_line_i,
    input  logic                  flush_i
);

    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [TAG_BITS-1:0]   tag_d  [NUM_LINES];
    logic [LINE_WIDTH-1:0] data_q [NUM_LINES];
    logic [LINE_WIDTH-1:0] data_d [NUM_LINES];

    // A fill in the same cycle as a flush leaves its own line valid.
    always_comb begin
        valid_d = flush_i ? '0 : valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
            tag_d[wr_idx_i]   = wr_tag_i;
            data_d[wr_idx_i]  = wr_line_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_line_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, whole-line refill on miss.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_BYTES = DEF_LINE_BYTES
) (
    input  logic    clk_i,
    input  logic    rst_i,
    icache_if.slave bus
);

    localparam int LINE_WIDTH = LINE_BYTES * 8;
    localparam int OFF_BITS   = off_bits(LINE_BYTES);
    localparam int IDX_BITS   = idx_bits(NUM_LINES);
    localparam int TAG_BITS   = tag_bits(ADDR_WIDTH, NUM_LINES, LINE_BYTES);
    localparam int WORDS      = LINE_BYTES / 4;

    icache_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  instr_valid_q, instr_valid_d;
    instruction_t          instr_q, instr_d;

    logic                  accept;
    logic                  rd_hit;
    logic [LINE_WIDTH-1:0] rd_line;
    logic                  wr_en;

    // Word select is pc[OFF-1:2]; the byte-in-word bits are shifted away.
    function automatic instruction_t pick_word(input logic [LINE_WIDTH-1:0] line,
                                               input logic [ADDR_WIDTH-1:0] pc);
        logic [ADDR_WIDTH-1:0] sel;
        pick_word = '0;
        sel = (pc >> 2) & ADDR_WIDTH'(WORDS - 1);
        for (int k = 0; k < WORDS; k++) begin
            if (sel == ADDR_WIDTH'(k)) pick_word = line[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    assign accept = bus.req_valid_i && (state_q == IDLE);
    assign wr_en  = (state_q == WAIT) && bus.mem_resp_valid_i;

    icache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS),
        .LINE_WIDTH(LINE_WIDTH)
    ) u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx_i (bus.req_pc_i[OFF_BITS +: IDX_BITS]),
        .rd_tag_i (bus.req_pc_i[ADDR_WIDTH-1 -: TAG_BITS]),
        .rd_hit_o (rd_hit),
        .rd_line_o(rd_line),
        .wr_en_i  (wr_en),
        .wr_idx_i (pc_q[OFF_BITS +: IDX_BITS]),
        .wr_tag_i (pc_q[ADDR_WIDTH-1 -: TAG_BITS]),
        .wr_line_i(bus.mem_resp_data_i),
        .flush_i  (bus.flush_i)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = 1'b0;
        instr_d       = instr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rd_hit) begin
                        instr_valid_d = 1'b1;
                        instr_d       = pick_word(rd_line, bus.req_pc_i);
                    end else begin
                        pc_d    = bus.req_pc_i;
                        state_d = REQ;
                    end
                end
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    instr_valid_d = 1'b1;
                    instr_d       = pick_word(bus.mem_resp_data_i, pc_q);
                    state_d       = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
        end
    end

    assign bus.req_ready_o     = (state_q == IDLE);
    assign bus.instr_valid_o   = instr_valid_q;
    assign bus.instr_o         = instr_q;
    assign bus.mem_req_valid_o = (state_q == REQ);
    assign bus.mem_req_addr_o  = {pc_q[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};

`ifndef SYNTHESIS
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        unused_cnt;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept && rd_hit && (hit_cnt_q != '1))    hit_cnt_d  = hit_cnt_q + 32'd1;
        if (accept && !rd_hit && (miss_cnt_q != '1))  miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign unused_cnt = ^{hit_cnt_q, miss_cnt_q};
`endif

endmodule
